// File: rtl/id_operand_hazard_unit_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | id_operand_hazard_unit_pkg: shared field widths and defaults      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package id_operand_hazard_unit_pkg;
  localparam int         REG_ADDR_W      = 5;
  localparam int         INST_W          = 32;
  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MDU_LAT_DEFAULT = 33;
endpackage
`default_nettype wire

// File: rtl/id_operand_hazard_unit_fwd_select.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | id_operand_hazard_unit_fwd_select: youngest-first forwarding mux  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module id_operand_hazard_unit_fwd_select
  import id_operand_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) (
  input  logic [REG_ADDR_W-1:0]         src_addr,
  input  logic                          uses_src,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD-1:0]            fwd_dvalid,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic [DATA_W-1:0]             data,
  output logic                          stall
);

  logic found;

  always_comb begin
    data  = rf_rdata;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      // Once the youngest match is taken, older producers are ignored entirely.
      if (!found && fwd_we[i] && (src_addr != REG_ZERO) &&
          (fwd_waddr[REG_ADDR_W*i +: REG_ADDR_W] == src_addr)) begin
        found = 1'b1;
        if (fwd_dvalid[i]) begin
          data = fwd_wdata[DATA_W*i +: DATA_W];
        end else begin
          stall = uses_src;
        end
      end
    end
    if (src_addr == REG_ZERO) begin
      data = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_operand_hazard_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | id_operand_hazard_unit: ID instruction hold, operand forwarding,  |
// | data and HI/LO stall generation.  Rev 1.0                         |
// +-------------------------------------------------------------------+
module id_operand_hazard_unit
  import id_operand_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_id,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [INST_W-1:0]             inst_sram_rdata,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD-1:0]            fwd_dvalid,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic                          uses_rs,
  input  logic                          uses_rt,
  input  logic                          uses_hilo,
  input  logic                          mdu_issue,
  output logic [INST_W-1:0]             inst,
  output logic [REG_ADDR_W-1:0]         raddr1,
  output logic [REG_ADDR_W-1:0]         raddr2,
  output logic [DATA_W-1:0]             rs_data,
  output logic [DATA_W-1:0]             rt_data,
  output logic                          stallreq,
  output logic                          stall_data,
  output logic                          stall_hilo,
  output logic                          mdu_busy
);

  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic              hold_vld_q,  hold_vld_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              stall_rs,    stall_rt;

  always_comb begin
    hold_inst_d = hold_inst_q;
    hold_vld_d  = hold_vld_q;
    if (flush) begin
      hold_vld_d = 1'b0;
    end else if (stall_id && !hold_vld_q) begin
      hold_inst_d = inst_sram_rdata;
      hold_vld_d  = 1'b1;
    end else if (!stall_id) begin
      hold_vld_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mdu_issue) begin
      cnt_d = CNT_W'(MDU_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_inst_q <= '0;
      hold_vld_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hold_inst_q <= hold_inst_d;
      hold_vld_q  <= hold_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    inst = '0;
    if (id_valid) begin
      inst = hold_vld_q ? hold_inst_q : inst_sram_rdata;
    end
  end

  assign raddr1 = inst[25:21];
  assign raddr2 = inst[20:16];

  id_operand_hazard_unit_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .DATA_W  (DATA_W)
  ) u_fwd_rs (
    .src_addr   (raddr1),
    .uses_src   (uses_rs),
    .fwd_we     (fwd_we),
    .fwd_dvalid (fwd_dvalid),
    .fwd_waddr  (fwd_waddr),
    .fwd_wdata  (fwd_wdata),
    .rf_rdata   (rf_rdata1),
    .data       (rs_data),
    .stall      (stall_rs)
  );

  id_operand_hazard_unit_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .DATA_W  (DATA_W)
  ) u_fwd_rt (
    .src_addr   (raddr2),
    .uses_src   (uses_rt),
    .fwd_we     (fwd_we),
    .fwd_dvalid (fwd_dvalid),
    .fwd_waddr  (fwd_waddr),
    .fwd_wdata  (fwd_wdata),
    .rf_rdata   (rf_rdata2),
    .data       (rt_data),
    .stall      (stall_rt)
  );

  assign mdu_busy   = (cnt_q != '0);
  assign stall_hilo = uses_hilo & mdu_busy;
  assign stall_data = stall_rs | stall_rt;
  assign stallreq   = stall_data | stall_hilo;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_hazard_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_id_operand_hazard_unit: directed + random check against a      |
// | behavioural model of the ID operand/hazard unit. Rev 1.0          |
// +-------------------------------------------------------------------+
module tb_id_operand_hazard_unit;
  localparam int NUM_FWD = 3;
  localparam int DATA_W  = 32;
  localparam int LAT     = 33;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall_id, flush, id_valid;
  logic [31:0]            inst_sram_rdata;
  logic [NUM_FWD-1:0]     fwd_we, fwd_dvalid;
  logic [5*NUM_FWD-1:0]   fwd_waddr;
  logic [32*NUM_FWD-1:0]  fwd_wdata;
  logic [31:0]            rf_rdata1, rf_rdata2;
  logic                   uses_rs, uses_rt, uses_hilo, mdu_issue;
  logic [31:0]            inst;
  logic [4:0]             raddr1, raddr2;
  logic [31:0]            rs_data, rt_data;
  logic                   stallreq, stall_data, stall_hilo, mdu_busy;

  int total = 0;
  int bad   = 0;

  // behavioural state
  logic        m_hold_vld;
  logic [31:0] m_hold_inst;
  int          m_cnt;

  always #5 clk = ~clk;

  id_operand_hazard_unit #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .MDU_LAT(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .flush(flush), .id_valid(id_valid),
    .inst_sram_rdata(inst_sram_rdata), .fwd_we(fwd_we), .fwd_dvalid(fwd_dvalid),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_hilo(uses_hilo), .mdu_issue(mdu_issue),
    .inst(inst), .raddr1(raddr1), .raddr2(raddr2), .rs_data(rs_data), .rt_data(rt_data),
    .stallreq(stallreq), .stall_data(stall_data), .stall_hilo(stall_hilo), .mdu_busy(mdu_busy)
  );

  // A new mult/div must never be issued while the HI/LO unit is still busy.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(mdu_issue && mdu_busy)) else begin
        bad++;
        $error("FAIL mdu_issue_while_busy obs=1 exp=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Oldest producer first, younger matches overwrite: the survivor is the youngest.
  task automatic ref_fwd(input logic [4:0] a, input logic use_s, input logic [31:0] rf,
                         output logic [31:0] d, output logic st);
    int hit;
    hit = -1;
    d   = rf;
    st  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == a) hit = i;
    if (a == 5'd0) d = 32'd0;
    else if (hit >= 0) begin
      if (fwd_dvalid[hit]) d = fwd_wdata[32*hit +: 32];
      else st = use_s;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_inst, e_rs, e_rt;
    logic        e_sr, e_st, e_busy, e_sh;
    e_inst = !id_valid ? 32'd0 : (m_hold_vld ? m_hold_inst : inst_sram_rdata);
    ref_fwd(e_inst[25:21], uses_rs, rf_rdata1, e_rs, e_sr);
    ref_fwd(e_inst[20:16], uses_rt, rf_rdata2, e_rt, e_st);
    e_busy = (m_cnt != 0);
    e_sh   = uses_hilo && e_busy;
    chk({tag, ".inst"},       inst,              e_inst);
    chk({tag, ".raddr1"},     {27'd0, raddr1},   {27'd0, e_inst[25:21]});
    chk({tag, ".raddr2"},     {27'd0, raddr2},   {27'd0, e_inst[20:16]});
    chk({tag, ".rs_data"},    rs_data,           e_rs);
    chk({tag, ".rt_data"},    rt_data,           e_rt);
    chk({tag, ".stall_data"}, {31'd0, stall_data}, {31'd0, e_sr | e_st});
    chk({tag, ".stall_hilo"}, {31'd0, stall_hilo}, {31'd0, e_sh});
    chk({tag, ".stallreq"},   {31'd0, stallreq},   {31'd0, e_sr | e_st | e_sh});
    chk({tag, ".mdu_busy"},   {31'd0, mdu_busy},   {31'd0, e_busy});
  endtask

  // Advance the model by one edge using the inputs currently applied, then move to edge+1.
  task automatic step();
    if (rst) begin
      if (flush) m_hold_vld = 1'b0;
      else if (stall_id && !m_hold_vld) begin
        m_hold_inst = inst_sram_rdata;
        m_hold_vld  = 1'b1;
      end else if (!stall_id) m_hold_vld = 1'b0;
      if (mdu_issue) m_cnt = LAT;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0000};
  endfunction

  initial begin
    rst = 1'b0; stall_id = 0; flush = 0; id_valid = 1; inst_sram_rdata = mk_inst(5, 8);
    fwd_we = '0; fwd_dvalid = '0; fwd_waddr = '0; fwd_wdata = '0;
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    uses_rs = 1; uses_rt = 1; uses_hilo = 1; mdu_issue = 0;
    m_hold_vld = 0; m_hold_inst = 0; m_cnt = 0;
    #1;
    chk("reset.mdu_busy", {31'd0, mdu_busy}, 32'd0);
    chk("reset.stall_hilo", {31'd0, stall_hilo}, 32'd0);
    check_all("reset");
    step();
    rst = 1'b1;

    // No producers: regfile data
    #2; chk("norm.rs", rs_data, 32'h1234); chk("norm.stallreq", {31'd0, stallreq}, 32'd0);
    check_all("norm");
    step();

    // Stage0 and stage2 both write r5: youngest wins
    fwd_we = 3'b101; fwd_dvalid = 3'b111;
    fwd_waddr = {5'd5, 5'd9, 5'd5}; fwd_wdata = {32'hC, 32'hB, 32'hA};
    #2; chk("prio.young", rs_data, 32'hA); check_all("prio.young");
    step();
    fwd_we = 3'b100;
    #2; chk("prio.old", rs_data, 32'hC); check_all("prio.old");
    step();

    // Load-use on rt=8
    fwd_we = 3'b001; fwd_dvalid = 3'b000; fwd_waddr = {5'd0, 5'd0, 5'd8};
    #2; chk("load.stall", {31'd0, stall_data}, 32'd1); chk("load.rt", rt_data, 32'h5678);
    check_all("load.use");
    step();
    uses_rt = 0;
    #2; chk("load.nouse", {31'd0, stall_data}, 32'd0); check_all("load.nouse");
    step();

    // r0 never forwards and reads zero
    uses_rt = 1; inst_sram_rdata = mk_inst(5, 0);
    fwd_we = 3'b001; fwd_dvalid = 3'b001; fwd_waddr = '0; fwd_wdata = {64'd0, 32'h55};
    #2; chk("zero.rt", rt_data, 32'd0); check_all("zero");
    step();
    fwd_we = '0;

    // Hold buffer across a 3-cycle stall
    stall_id = 1; inst_sram_rdata = 32'h111;
    #2; check_all("hold.c0"); step();
    inst_sram_rdata = 32'h222;
    #2; chk("hold.c1", inst, 32'h111); check_all("hold.c1"); step();
    #2; chk("hold.c2", inst, 32'h111); check_all("hold.c2"); step();
    stall_id = 0;
    #2; chk("hold.rel", inst, 32'h111); check_all("hold.rel"); step();
    #2; chk("hold.after", inst, 32'h222); check_all("hold.after"); step();

    // Flush during a stall empties the buffer
    stall_id = 1; inst_sram_rdata = 32'h333;
    #2; check_all("flush.c0"); step();
    inst_sram_rdata = 32'h444; flush = 1;
    #2; check_all("flush.c1"); step();
    flush = 0; stall_id = 0;
    #2; chk("flush.follow", inst, 32'h444); check_all("flush.follow"); step();
    id_valid = 0;
    #2; chk("invalid.inst", inst, 32'd0); check_all("invalid"); step();
    id_valid = 1;

    // HI/LO busy window
    uses_hilo = 1; mdu_issue = 1;
    #2; chk("mdu.c0", {31'd0, stall_hilo}, 32'd0); step();
    mdu_issue = 0;
    for (int k = 1; k <= LAT; k++) begin
      #2; chk("mdu.busy", {31'd0, stall_hilo}, 32'd1); check_all("mdu.win"); step();
    end
    #2; chk("mdu.done", {31'd0, stall_hilo}, 32'd0); check_all("mdu.done"); step();

    // Asynchronous reset while busy at cnt=10
    mdu_issue = 1; #2; step(); mdu_issue = 0;
    repeat (LAT - 10) step();
    #2; chk("rstmid.pre", {31'd0, mdu_busy}, 32'd1);
    rst = 0; m_cnt = 0; m_hold_vld = 0; m_hold_inst = 0;
    #1; chk("rstmid.busy", {31'd0, mdu_busy}, 32'd0); check_all("rstmid");
    step();
    rst = 1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      stall_id  = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      id_valid  = ($urandom_range(0, 7) != 0);
      inst_sram_rdata = {$urandom} & 32'hFC63_FFFF | {6'd0, 3'd0, 2'($urandom), 3'd0, 2'($urandom), 16'd0};
      fwd_we     = NUM_FWD'($urandom);
      fwd_dvalid = NUM_FWD'($urandom);
      for (int s = 0; s < NUM_FWD; s++) begin
        fwd_waddr[5*s +: 5]  = 5'($urandom_range(0, 3));
        fwd_wdata[32*s +: 32] = $urandom;
      end
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      uses_rs = 1'($urandom); uses_rt = 1'($urandom); uses_hilo = 1'($urandom);
      mdu_issue = (m_cnt == 0) && ($urandom_range(0, 7) == 0);
      #2; check_all("rand");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
